// File: rtl/arb_vc_dest_pkg.sv
// Shared definitions for the VC-to-destination weighted round-robin scheduler.
package arb_vc_dest_pkg;

  // Which VC currently owns the round-robin turn.
  typedef enum logic {
    TURN_VC0 = 1'b0,
    TURN_VC1 = 1'b1
  } owner_e;

  // Default word bit that selects the destination FIFO (0 -> D0, 1 -> D1).
  localparam int DEST_BIT_DEF = 4;

  // Width of the per-turn grant counter; weights are limited to 1..15.
  localparam int CNT_W = 4;

  // The VC that is not the current owner.
  function automatic owner_e other_vc(input owner_e owner);
    owner_e res;
    case (owner)
      TURN_VC0: res = TURN_VC1;
      TURN_VC1: res = TURN_VC0;
      default:  res = TURN_VC0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/arb_vc_dest_if.sv
// Bundle of VC FIFO heads, destination back-pressure, pops and the demux feed.
interface arb_vc_dest_if #(
  parameter int BW = 6
);
  logic          vc0_empty;
  logic [BW-1:0] vc0_data;
  logic          vc1_empty;
  logic [BW-1:0] vc1_data;
  logic          d0_afull;
  logic          d1_afull;
  logic          vc0_pop;
  logic          vc1_pop;
  logic [BW-1:0] data_out;
  logic          valid_out;

  // Scheduler side: consumes FIFO heads and back-pressure, drives pops and data.
  modport master (
    input  vc0_empty, vc0_data, vc1_empty, vc1_data, d0_afull, d1_afull,
    output vc0_pop, vc1_pop, data_out, valid_out
  );

  // Environment side: FIFOs and demux.
  modport slave (
    output vc0_empty, vc0_data, vc1_empty, vc1_data, d0_afull, d1_afull,
    input  vc0_pop, vc1_pop, data_out, valid_out
  );
endinterface

// File: rtl/arb_vc_dest_vc_elig.sv
// Per-VC eligibility: head word present and its destination not almost-full.
module vc_elig
  import arb_vc_dest_pkg::*;
#(
  parameter int BW       = 6,
  parameter int DEST_BIT = DEST_BIT_DEF
) (
  input  logic          empty,
  input  logic [BW-1:0] data,
  input  logic          d0_afull,
  input  logic          d1_afull,
  output logic          elig
);

  logic dst_afull_s;

  // Select the back-pressure of the destination this head word is heading to.
  always_comb begin
    dst_afull_s = 1'b0;
    if (data[DEST_BIT]) begin
      dst_afull_s = d1_afull;
    end else begin
      dst_afull_s = d0_afull;
    end
    elig = !empty && !dst_afull_s;
  end

endmodule

// File: rtl/arb_vc_dest.sv
// Weighted round-robin scheduler from VC0/VC1 FIFOs into the destination demux.
module arb_vc_dest
  import arb_vc_dest_pkg::*;
#(
  parameter int BW       = 6,
  parameter int DEST_BIT = DEST_BIT_DEF,
  parameter int WEIGHT0  = 3,
  parameter int WEIGHT1  = 1
) (
  input  logic          clk,
  input  logic          reset,
  arb_vc_dest_if.master bus
);

  localparam logic [CNT_W-1:0] W0_C = CNT_W'(WEIGHT0);
  localparam logic [CNT_W-1:0] W1_C = CNT_W'(WEIGHT1);

  logic             elg0_s;
  logic             elg1_s;
  owner_e           owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BW-1:0]    data_q, data_d;
  logic             valid_q, valid_d;
  logic             pop0_s, pop1_s;
  logic [CNT_W-1:0] w_own_s;
  logic             elg_own_s, elg_oth_s;
  logic             grant_own_s, grant_oth_s;

  vc_elig #(.BW(BW), .DEST_BIT(DEST_BIT)) u_elig0 (
    .empty    (bus.vc0_empty),
    .data     (bus.vc0_data),
    .d0_afull (bus.d0_afull),
    .d1_afull (bus.d1_afull),
    .elig     (elg0_s)
  );

  vc_elig #(.BW(BW), .DEST_BIT(DEST_BIT)) u_elig1 (
    .empty    (bus.vc1_empty),
    .data     (bus.vc1_data),
    .d0_afull (bus.d0_afull),
    .d1_afull (bus.d1_afull),
    .elig     (elg1_s)
  );

  // Grant decision, pops and next turn state; the counter saturates at the
  // owner's weight so an unchallenged owner keeps the bus indefinitely.
  always_comb begin
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    pop0_s      = 1'b0;
    pop1_s      = 1'b0;
    w_own_s     = W0_C;
    elg_own_s   = 1'b0;
    elg_oth_s   = 1'b0;
    grant_own_s = 1'b0;
    grant_oth_s = 1'b0;

    case (owner_q)
      TURN_VC0: begin
        w_own_s   = W0_C;
        elg_own_s = elg0_s;
        elg_oth_s = elg1_s;
      end
      TURN_VC1: begin
        w_own_s   = W1_C;
        elg_own_s = elg1_s;
        elg_oth_s = elg0_s;
      end
      default: begin
        w_own_s   = W0_C;
        elg_own_s = 1'b0;
        elg_oth_s = 1'b0;
      end
    endcase

    grant_own_s = elg_own_s && ((cnt_q < w_own_s) || !elg_oth_s);
    grant_oth_s = !grant_own_s && elg_oth_s;

    if (reset) begin
      pop0_s = 1'b0;
      pop1_s = 1'b0;
    end else if (grant_own_s) begin
      cnt_d  = (cnt_q < w_own_s) ? (cnt_q + 4'd1) : w_own_s;
      pop0_s = (owner_q == TURN_VC0);
      pop1_s = (owner_q == TURN_VC1);
    end else if (grant_oth_s) begin
      owner_d = other_vc(owner_q);
      cnt_d   = 4'd1;
      pop0_s  = (owner_q == TURN_VC1);
      pop1_s  = (owner_q == TURN_VC0);
    end else begin
      owner_d = owner_q;
      cnt_d   = cnt_q;
    end

    valid_d = pop0_s | pop1_s;
    if (pop0_s) begin
      data_d = bus.vc0_data;
    end else if (pop1_s) begin
      data_d = bus.vc1_data;
    end else begin
      data_d = {BW{1'b0}};
    end
  end

  // Turn state and registered demux feed.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q <= TURN_VC0;
      cnt_q   <= {CNT_W{1'b0}};
      valid_q <= 1'b0;
      data_q  <= {BW{1'b0}};
    end else begin
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign bus.vc0_pop   = pop0_s;
  assign bus.vc1_pop   = pop1_s;
  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;

endmodule

// File: tb/tb_arb_vc_dest.sv
// Directed bench for arb_vc_dest: default weights (3/1) and a 1/2 instance.
module tb_arb_vc_dest;
  import arb_vc_dest_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic [5:0] w0 [64];
  logic [5:0] w1 [64];
  int   i0, i1, n0, n1;
  logic exp_valid;
  logic [5:0] exp_word;

  arb_vc_dest_if #(.BW(6)) bus_a ();
  arb_vc_dest_if #(.BW(6)) bus_b ();

  arb_vc_dest #(.BW(6), .DEST_BIT(4), .WEIGHT0(3), .WEIGHT1(1)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  arb_vc_dest #(.BW(6), .DEST_BIT(4), .WEIGHT0(1), .WEIGHT1(2)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a runaway simulation.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_a.vc0_empty = 1'b1; bus_a.vc1_empty = 1'b1;
    bus_a.vc0_data  = 6'd0; bus_a.vc1_data  = 6'd0;
    bus_a.d0_afull  = 1'b0; bus_a.d1_afull  = 1'b0;
    bus_b.vc0_empty = 1'b1; bus_b.vc1_empty = 1'b1;
    bus_b.vc0_data  = 6'd0; bus_b.vc1_data  = 6'd0;
    bus_b.d0_afull  = 1'b0; bus_b.d1_afull  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus_a.vc0_empty = 1'b0;
    bus_a.vc1_empty = 1'b0;
    bus_a.vc0_data  = 6'd5;
    reset = 1'b1;
    tick();
    tick();
    #4;
    checks++;
    if ({bus_a.vc0_pop, bus_a.vc1_pop} !== 2'b00) begin
      failures++;
      $display("FAIL reset_pops: got %b required 00", {bus_a.vc0_pop, bus_a.vc1_pop});
    end
    checks++;
    if (bus_a.valid_out !== 1'b0 || bus_a.data_out !== 6'd0) begin
      failures++;
      $display("FAIL reset_out: got valid=%b data=%0h required valid=0 data=0", bus_a.valid_out, bus_a.data_out);
    end
    checks++;
    if (dut_a.owner_q !== TURN_VC0 || dut_a.cnt_q !== 4'd0) begin
      failures++;
      $display("FAIL reset_state: got owner=%0d cnt=%0d required owner=0 cnt=0", dut_a.owner_q, dut_a.cnt_q);
    end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic e0, e1;
    do_reset();
    i0 = 0; i1 = 0; exp_valid = 1'b0; exp_word = 6'd0;
    bus_a.vc0_empty = 1'b0; bus_a.vc1_empty = 1'b0;
    bus_a.vc0_data  = w0[0]; bus_a.vc1_data = w1[0];
    for (int k = 0; k < 12; k++) begin
      #4;
      e0 = ((k % 4) != 3);
      e1 = !e0;
      checks++;
      if ({bus_a.vc0_pop, bus_a.vc1_pop} !== {e0, e1}) begin
        failures++;
        $display("FAIL basic_pop[%0d]: got %b required %b", k, {bus_a.vc0_pop, bus_a.vc1_pop}, {e0, e1});
      end
      checks++;
      if (bus_a.valid_out !== exp_valid || bus_a.data_out !== exp_word) begin
        failures++;
        $display("FAIL basic_out[%0d]: got valid=%b data=%0h required valid=%b data=%0h", k, bus_a.valid_out, bus_a.data_out, exp_valid, exp_word);
      end
      exp_valid = 1'b1;
      exp_word  = e0 ? w0[n0] : w1[n1];
      if (e0) n0++; else n1++;
      if (bus_a.vc0_pop) i0++;
      if (bus_a.vc1_pop) i1++;
      tick();
      bus_a.vc0_data = w0[i0];
      bus_a.vc1_data = w1[i1];
    end
  endtask

  task automatic test_vc1_empty();
    do_reset();
    bus_a.vc0_empty = 1'b0; bus_a.vc0_data = w0[5];
    bus_a.vc1_empty = 1'b1; bus_a.vc1_data = w1[7];
    for (int k = 0; k < 6; k++) begin
      #4;
      checks++;
      if ({bus_a.vc0_pop, bus_a.vc1_pop} !== 2'b10) begin
        failures++;
        $display("FAIL solo_pop[%0d]: got %b required 10", k, {bus_a.vc0_pop, bus_a.vc1_pop});
      end
      tick();
    end
    checks++;
    if (dut_a.cnt_q !== 4'd3 || dut_a.owner_q !== TURN_VC0) begin
      failures++;
      $display("FAIL solo_sat: got owner=%0d cnt=%0d required owner=0 cnt=3", dut_a.owner_q, dut_a.cnt_q);
    end
    bus_a.vc1_empty = 1'b0;
    #4;
    checks++;
    if ({bus_a.vc0_pop, bus_a.vc1_pop} !== 2'b01) begin
      failures++;
      $display("FAIL solo_yield: got %b required 01", {bus_a.vc0_pop, bus_a.vc1_pop});
    end
    tick();
    #4;
    checks++;
    if (bus_a.valid_out !== 1'b1 || bus_a.data_out !== w1[7]) begin
      failures++;
      $display("FAIL solo_data: got valid=%b data=%0h required valid=1 data=%0h", bus_a.valid_out, bus_a.data_out, w1[7]);
    end
    checks++;
    if ({bus_a.vc0_pop, bus_a.vc1_pop} !== 2'b10) begin
      failures++;
      $display("FAIL solo_back: got %b required 10", {bus_a.vc0_pop, bus_a.vc1_pop});
    end
    tick();
  endtask

  task automatic test_dest_block();
    do_reset();
    bus_a.vc0_empty = 1'b0; bus_a.vc0_data = 6'b010000;
    bus_a.vc1_empty = 1'b0; bus_a.vc1_data = 6'b000001;
    bus_a.d1_afull  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #4;
      checks++;
      if ({bus_a.vc0_pop, bus_a.vc1_pop} !== 2'b01) begin
        failures++;
        $display("FAIL block_pop[%0d]: got %b required 01", k, {bus_a.vc0_pop, bus_a.vc1_pop});
      end
      tick();
    end
    #4;
    checks++;
    if (bus_a.valid_out !== 1'b1 || bus_a.data_out !== 6'b000001) begin
      failures++;
      $display("FAIL block_data: got valid=%b data=%0h required valid=1 data=1", bus_a.valid_out, bus_a.data_out);
    end
    tick();
    bus_a.d1_afull = 1'b0;
    #4;
    checks++;
    if ({bus_a.vc0_pop, bus_a.vc1_pop} !== 2'b10) begin
      failures++;
      $display("FAIL release_pop: got %b required 10", {bus_a.vc0_pop, bus_a.vc1_pop});
    end
    tick();
    #4;
    checks++;
    if (bus_a.valid_out !== 1'b1 || bus_a.data_out !== 6'b010000) begin
      failures++;
      $display("FAIL release_data: got valid=%b data=%0h required valid=1 data=10", bus_a.valid_out, bus_a.data_out);
    end
    tick();
  endtask

  task automatic test_stall();
    do_reset();
    bus_a.vc0_empty = 1'b0; bus_a.vc0_data = w0[1];
    bus_a.vc1_empty = 1'b0; bus_a.vc1_data = w1[1];
    tick();
    tick();
    bus_a.d0_afull = 1'b1;
    bus_a.d1_afull = 1'b1;
    for (int j = 0; j < 5; j++) begin
      #4;
      checks++;
      if ({bus_a.vc0_pop, bus_a.vc1_pop} !== 2'b00 || bus_a.valid_out !== (j == 0)) begin
        failures++;
        $display("FAIL stall_out[%0d]: got pops=%b valid=%b required pops=00 valid=%b", j, {bus_a.vc0_pop, bus_a.vc1_pop}, bus_a.valid_out, (j == 0));
      end
      checks++;
      if (dut_a.owner_q !== TURN_VC0 || dut_a.cnt_q !== 4'd2) begin
        failures++;
        $display("FAIL stall_state[%0d]: got owner=%0d cnt=%0d required owner=0 cnt=2", j, dut_a.owner_q, dut_a.cnt_q);
      end
      tick();
    end
    bus_a.d0_afull = 1'b0;
    bus_a.d1_afull = 1'b0;
    #4;
    checks++;
    if ({bus_a.vc0_pop, bus_a.vc1_pop} !== 2'b10) begin
      failures++;
      $display("FAIL stall_resume: got %b required 10", {bus_a.vc0_pop, bus_a.vc1_pop});
    end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus_a.vc0_empty = 1'b0; bus_a.vc0_data = w0[2];
    bus_a.vc1_empty = 1'b0; bus_a.vc1_data = w1[2];
    tick();
    tick();
    tick();
    reset = 1'b1;
    #4;
    checks++;
    if ({bus_a.vc0_pop, bus_a.vc1_pop} !== 2'b00) begin
      failures++;
      $display("FAIL midreset_pop: got %b required 00", {bus_a.vc0_pop, bus_a.vc1_pop});
    end
    tick();
    reset = 1'b0;
    #4;
    checks++;
    if (bus_a.valid_out !== 1'b0 || bus_a.data_out !== 6'd0) begin
      failures++;
      $display("FAIL midreset_out: got valid=%b data=%0h required valid=0 data=0", bus_a.valid_out, bus_a.data_out);
    end
    checks++;
    if (dut_a.owner_q !== TURN_VC0 || dut_a.cnt_q !== 4'd0) begin
      failures++;
      $display("FAIL midreset_state: got owner=%0d cnt=%0d required owner=0 cnt=0", dut_a.owner_q, dut_a.cnt_q);
    end
    tick();
  endtask

  task automatic test_weights();
    logic e0, e1;
    do_reset();
    i0 = 0; i1 = 0; n0 = 0; n1 = 0; exp_valid = 1'b0; exp_word = 6'd0;
    bus_b.vc0_empty = 1'b0; bus_b.vc1_empty = 1'b0;
    bus_b.vc0_data  = w0[0]; bus_b.vc1_data = w1[0];
    for (int k = 0; k < 30; k++) begin
      #4;
      e0 = ((k % 3) == 0);
      e1 = !e0;
      checks++;
      if ({bus_b.vc0_pop, bus_b.vc1_pop} !== {e0, e1}) begin
        failures++;
        $display("FAIL wrr_pop[%0d]: got %b required %b", k, {bus_b.vc0_pop, bus_b.vc1_pop}, {e0, e1});
      end
      checks++;
      if (bus_b.valid_out !== exp_valid || bus_b.data_out !== exp_word) begin
        failures++;
        $display("FAIL wrr_out[%0d]: got valid=%b data=%0h required valid=%b data=%0h", k, bus_b.valid_out, bus_b.data_out, exp_valid, exp_word);
      end
      exp_valid = 1'b1;
      exp_word  = e0 ? w0[n0] : w1[n1];
      if (e0) n0++; else n1++;
      if (bus_b.vc0_pop) i0++;
      if (bus_b.vc1_pop) i1++;
      tick();
      bus_b.vc0_data = w0[i0];
      bus_b.vc1_data = w1[i1];
    end
  endtask

  // Test sequence.
  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    for (int i = 0; i < 64; i++) begin
      w0[i] = 6'(i + 1);
      w1[i] = 6'(32 + i);
    end
    n0 = 0; n1 = 0;
    idle_inputs();
    tick();
    test_reset();
    n0 = 0; n1 = 0;
    test_basic();
    test_vc1_empty();
    test_dest_block();
    test_stall();
    test_reset_mid();
    test_weights();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
